// File: rtl/wb_pkg.sv
// Shared state encoding and bus constants for the button-driven Wishbone initiator.
package wb_pkg;

   localparam int unsigned WB_DW = 32;

`ifdef FORMAL
   localparam int unsigned DEB_DEFAULT = 4;
`else
   localparam int unsigned DEB_DEFAULT = 50_000;
`endif

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWrReq    = 3'd1,
      StWrWait   = 3'd2,
      StPollReq  = 3'd3,
      StPollWait = 3'd4
   } wb_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counter debouncer and one-cycle rising-edge pulse for a raw button.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          stable_q, stable_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         sync_q   <= 2'b00;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], i_btn};
         stable_q <= stable_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end

   // Counter tracks consecutive cycles the synchronised level differs from the accepted one.
   always_comb begin
      stable_d = stable_q;
      press_d  = 1'b0;
      cnt_d    = cnt_q;
      if (sync_q[1] == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync_q[1];
         press_d  = sync_q[1];
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign o_level = stable_q;
   assign o_press = press_q;

endmodule

// File: rtl/wb_btn_master.sv
// Wishbone pipelined initiator issuing one single-beat write per debounced button press.
// Build option: define STATUS_POLL_EN to poll WR_ADDR after each write until it reads zero.
module wb_btn_master
   import wb_pkg::*;
#(
   parameter int unsigned      DEBOUNCE_CYCLES = DEB_DEFAULT,
   parameter int unsigned      ACK_TIMEOUT     = 1023,
   parameter int unsigned      AW              = 1,
   parameter logic [AW-1:0]    WR_ADDR         = '0,
   parameter logic [WB_DW-1:0] WR_DATA         = 32'h0
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_btn,
   output logic             o_wb_cyc,
   output logic             o_wb_stb,
   output logic             o_wb_we,
   output logic [AW-1:0]    o_wb_addr,
   output logic [WB_DW-1:0] o_wb_data,
   input  logic             i_wb_stall,
   input  logic             i_wb_ack,
   input  logic [WB_DW-1:0] i_wb_data,
   output logic             o_busy,
   output logic             o_err,
   output logic [WB_DW-1:0] o_status
);

   localparam int unsigned   TW       = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

   wb_state_e     state_q, state_d;
   logic          err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          press;
   logic          unused_level;
   logic          cyc, stb, we;
   logic          beat_done;

`ifdef STATUS_POLL_EN
   logic             gap_q, gap_d;
   logic [WB_DW-1:0] status_q, status_d;
`else
   logic unused_rdata;
   assign unused_rdata = ^i_wb_data;
`endif

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .i_btn    (i_btn),
      .o_level  (unused_level),
      .o_press  (press)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q  <= StIdle;
         err_q    <= 1'b0;
         tmo_q    <= '0;
`ifdef STATUS_POLL_EN
         gap_q    <= 1'b0;
         status_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
`ifdef STATUS_POLL_EN
         gap_q    <= gap_d;
         status_q <= status_d;
`endif
      end
   end

   // Bus signals decode straight from state so a synchronous reset drops them on the same edge.
   always_comb begin
      cyc = (state_q != StIdle);
      stb = (state_q == StWrReq) || (state_q == StPollReq);
      we  = (state_q == StWrReq) || (state_q == StWrWait);
`ifdef STATUS_POLL_EN
      if (gap_q) begin
         cyc = 1'b0;
         stb = 1'b0;
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      tmo_d     = '0;
      beat_done = 1'b0;
`ifdef STATUS_POLL_EN
      gap_d     = 1'b0;
      status_d  = status_q;
`endif
      case (state_q)
         StIdle: begin
            if (press) begin
               state_d = StWrReq;
               err_d   = 1'b0;
            end
         end
         StWrReq: begin
            if (!i_wb_stall) begin
               if (i_wb_ack) beat_done = 1'b1;
               else          state_d   = StWrWait;
            end
         end
         StWrWait: begin
            if (i_wb_ack) beat_done = 1'b1;
         end
`ifdef STATUS_POLL_EN
         StPollReq: begin
            if (!gap_q && !i_wb_stall) begin
               if (i_wb_ack) beat_done = 1'b1;
               else          state_d   = StPollWait;
            end
         end
         StPollWait: begin
            if (i_wb_ack) beat_done = 1'b1;
         end
`endif
         default: state_d = StIdle;
      endcase

      if (beat_done) begin
`ifdef STATUS_POLL_EN
         // Every completed write, and every non-zero read, is followed by one idle gap and a read.
         if (!we) status_d = i_wb_data;
         if (we || (i_wb_data != '0)) begin
            state_d = StPollReq;
            gap_d   = 1'b1;
         end else begin
            state_d = StIdle;
         end
`else
         state_d = StIdle;
`endif
      end else if (cyc && (tmo_q == TMO_LAST)) begin
         state_d = StIdle;
         err_d   = 1'b1;
      end

      if (cyc && !beat_done && (state_d != StIdle) && (tmo_q != TMO_LAST)) begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   assign o_wb_cyc  = cyc;
   assign o_wb_stb  = stb;
   assign o_wb_we   = we;
   assign o_wb_addr = cyc ? WR_ADDR : '0;
   assign o_wb_data = we ? WR_DATA : '0;
   assign o_busy    = (state_q != StIdle);
   assign o_err     = err_q;
`ifdef STATUS_POLL_EN
   assign o_status  = status_q;
`else
   assign o_status  = '0;
`endif

endmodule

// File: tb/tb_wb_btn_master.sv
// Directed bench for wb_btn_master with a beat scoreboard and an acking responder model.
module tb_wb_btn_master;

   localparam int unsigned DEB   = 4;
   localparam int unsigned TMO   = 16;
   localparam int unsigned AW    = 4;
   localparam logic [3:0]  WADDR = 4'h9;
   localparam logic [31:0] WDATA = 32'hCAFE_0042;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          btn;
   logic          wb_cyc, wb_stb, wb_we;
   logic [AW-1:0] wb_addr;
   logic [31:0]   wb_wdata;
   logic          wb_stall, wb_ack;
   logic [31:0]   wb_rdata;
   logic          busy, err;
   logic [31:0]   status;

   int    total = 0;
   int    bad   = 0;
   int    cycle = 0;
   int    ack_cycle = 0;
   int    cyc_seen = 0;
   int    stb_seen = 0;
   int    rd_beats = 0;
   bit    ack_en = 1'b1;
   beat_t exp_q[$];
   logic [31:0] rq[$];

   wb_btn_master #(
      .DEBOUNCE_CYCLES(DEB),
      .ACK_TIMEOUT    (TMO),
      .AW             (AW),
      .WR_ADDR        (WADDR),
      .WR_DATA        (WDATA)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_btn     (btn),
      .o_wb_cyc  (wb_cyc),
      .o_wb_stb  (wb_stb),
      .o_wb_we   (wb_we),
      .o_wb_addr (wb_addr),
      .o_wb_data (wb_wdata),
      .i_wb_stall(wb_stall),
      .i_wb_ack  (wb_ack),
      .i_wb_data (wb_rdata),
      .o_busy    (busy),
      .o_err     (err),
      .o_status  (status)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // One clock: scoreboard any beat accepted at this edge, then model the responder's ack.
   task automatic step();
      logic acc, acc_we;
      beat_t e;
      acc    = (wb_stb === 1'b1) && (wb_stall === 1'b0);
      acc_we = wb_we;
      if (acc) begin
         chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_we", 32'(wb_we), 32'(e.we));
            chk("beat_addr", 32'(wb_addr), 32'(e.addr));
            if (e.we) chk("beat_data", wb_wdata, e.data);
         end
         if (!acc_we) rd_beats++;
      end
      if (wb_cyc === 1'b1) cyc_seen++;
      if (wb_stb === 1'b1) stb_seen++;
      @(posedge clk);
      #1;
      cycle++;
      wb_ack = 1'b0;
      if (acc && ack_en) begin
         wb_ack    = 1'b1;
         ack_cycle = cycle;
         if (!acc_we && rq.size() > 0) wb_rdata = rq.pop_front();
      end
   endtask

   // Raise the button and check that stb rises exactly DEB+3 edges later (or stays low if busy).
   task automatic press(input bit expect_beat);
      if (expect_beat) exp_q.push_back('{we: 1'b1, addr: WADDR, data: WDATA});
      btn = 1'b1;
      repeat (DEB + 2) step();
      chk("stb_before_latency", 32'(wb_stb), 32'd0);
      step();
      chk("stb_at_latency", 32'(wb_stb), 32'(expect_beat));
   endtask

   task automatic wait_idle(input int limit, input string tag);
      int n = 0;
      while (busy && n < limit) begin
         step();
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic release_settle();
      btn = 1'b0;
      repeat (DEB + 6) step();
   endtask

   initial begin
      int c0, s0, n;
      rst_n    = 1'b0;
      btn      = 1'b0;
      wb_stall = 1'b0;
      wb_ack   = 1'b0;
      wb_rdata = 32'h0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_cyc", 32'(wb_cyc), 32'd0);
      chk("rst_stb", 32'(wb_stb), 32'd0);
      chk("rst_we", 32'(wb_we), 32'd0);
      chk("rst_addr", 32'(wb_addr), 32'd0);
      chk("rst_data", wb_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_status", status, 32'd0);
      rst_n = 1'b1;
      repeat (2) step();

      // Basic write: single stb, ack one cycle later, busy clears promptly.
      s0 = stb_seen;
      press(1'b1);
      chk("basic_busy", 32'(busy), 32'd1);
      btn = 1'b0;
      wait_idle(20, "basic_idle");
      chk("basic_busy_drop", 32'(cycle - ack_cycle <= 3), 32'd1);
      chk("basic_stb_count", 32'(stb_seen - s0), 32'd1);
      chk("basic_err", 32'(err), 32'd0);
      chk("basic_status", status, 32'd0);
      release_settle();

      // Glitch shorter than the debounce window never starts a cycle.
      c0  = cyc_seen;
      btn = 1'b1;
      repeat (DEB - 1) step();
      btn = 1'b0;
      repeat (20) step();
      chk("glitch_no_cyc", 32'(cyc_seen - c0), 32'd0);

      // Ack while idle is ignored.
      wb_ack = 1'b1;
      @(posedge clk);
      #1;
      wb_ack = 1'b0;
      chk("idle_ack_busy", 32'(busy), 32'd0);
      chk("idle_ack_cyc", 32'(wb_cyc), 32'd0);

      // Stall holds the request stable for five cycles.
      wb_stall = 1'b1;
      press(1'b1);
      btn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_stb", 32'(wb_stb), 32'd1);
         chk("stall_we", 32'(wb_we), 32'd1);
         chk("stall_addr", 32'(wb_addr), 32'(WADDR));
         chk("stall_data", wb_wdata, WDATA);
         step();
      end
      wb_stall = 1'b0;
      chk("stall_release_stb", 32'(wb_stb), 32'd1);
      step();
      chk("stall_stb_drop", 32'(wb_stb), 32'd0);
      chk("stall_cyc_held", 32'(wb_cyc), 32'd1);
      wait_idle(20, "stall_idle");
      release_settle();

      // No ack: cycle aborts after TMO cycles with sticky error; next press clears it.
      ack_en = 1'b0;
      press(1'b1);
      btn = 1'b0;
      n = 0;
      while (wb_cyc && n < 40) begin
         n++;
         step();
      end
      chk("timeout_cycles", 32'(n), 32'(TMO));
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_busy", 32'(busy), 32'd0);
      release_settle();
      chk("timeout_err_sticky", 32'(err), 32'd1);
      ack_en = 1'b1;
      press(1'b1);
      chk("repress_err_clear", 32'(err), 32'd0);
      btn = 1'b0;
      wait_idle(20, "repress_idle");
      chk("repress_err", 32'(err), 32'd0);
      release_settle();

      // Second press during WR_WAIT is dropped; reset aborts the cycle on the next edge.
      ack_en = 1'b0;
      press(1'b1);
      btn = 1'b0;
      repeat (6) step();
      press(1'b0);
      chk("busy_press_stb", 32'(wb_stb), 32'd0);
      chk("busy_press_busy", 32'(busy), 32'd1);
      chk("busy_press_we", 32'(wb_we), 32'd1);
      btn   = 1'b0;
      rst_n = 1'b0;
      step();
      chk("midrst_cyc", 32'(wb_cyc), 32'd0);
      chk("midrst_stb", 32'(wb_stb), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      rst_n  = 1'b1;
      ack_en = 1'b1;
      c0 = cyc_seen;
      repeat (20) step();
      chk("midrst_no_restart", 32'(cyc_seen - c0), 32'd0);

`ifdef STATUS_POLL_EN
      // Poll reads 5, 3, 0 after the write.
      rq.push_back(32'd5);
      rq.push_back(32'd3);
      rq.push_back(32'd0);
      rd_beats = 0;
      press(1'b1);
      for (int i = 0; i < 3; i++) exp_q.push_back('{we: 1'b0, addr: WADDR, data: 32'h0});
      btn = 1'b0;
      wait_idle(100, "poll_idle");
      chk("poll_reads", 32'(rd_beats), 32'd3);
      chk("poll_status", status, 32'd0);
      chk("poll_err", 32'(err), 32'd0);
`else
      chk("status_tied", status, 32'd0);
`endif

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
